// File: rtl/gb_pkg.sv
// Shared Game Boy cartridge header definitions.
// Holds the header-check FSM states and header address map.
package gb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOGO,
      ST_CSUM,
      ST_HCHK,
      ST_FINISH
   } state_e;

   localparam logic [15:0] HDR_LOGO_START = 16'h0104;
   localparam logic [15:0] HDR_LOGO_END   = 16'h0133;
   localparam logic [15:0] HDR_CSUM_START = 16'h0134;
   localparam logic [15:0] HDR_CSUM_END   = 16'h014C;
   localparam logic [15:0] HDR_CSUM_ADDR  = 16'h014D;

endpackage

// File: rtl/cart_header_checker.sv
// Cartridge header checker: compares the logo against the boot ROM
// and verifies the header checksum at 0x014D, with a read timeout.
module cart_header_checker
   import gb_pkg::*;
#(
   parameter logic [7:0] LOGO_BASE = 8'hA8,
   parameter int         TIMEOUT   = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        logo_ok,
   output logic        csum_ok,
   output logic [7:0]  csum,
   output logic        timeout_err,
   output logic        rd_req,
   output logic [15:0] rd_addr,
   input  logic        rd_valid,
   input  logic [7:0]  rd_data,
   output logic [7:0]  logo_addr,
   input  logic [7:0]  logo_data
);

   localparam int WW = $clog2(TIMEOUT + 1);

   state_e        state_q, state_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          logo_ok_q, logo_ok_d;
   logic          csum_ok_q, csum_ok_d;
   logic [7:0]    csum_q, csum_d;
   logic          tmo_q, tmo_d;
   logic          rd_req_q, rd_req_d;
   logic [15:0]   rd_addr_q, rd_addr_d;
   logic [5:0]    idx_q, idx_d;
   logic [WW-1:0] wait_q, wait_d;
   logic          beat;
   logic          stall;

   assign beat      = rd_req_q & rd_valid;
   assign stall     = rd_req_q & ~rd_valid;
   assign logo_addr = LOGO_BASE + {2'b00, idx_q};

   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      logo_ok_d = logo_ok_q;
      csum_ok_d = csum_ok_q;
      csum_d    = csum_q;
      tmo_d     = tmo_q;
      rd_req_d  = rd_req_q;
      rd_addr_d = rd_addr_q;
      idx_d     = idx_q;
      wait_d    = wait_q;
      if (beat) begin
         wait_d = '0;
      end else if (stall) begin
         wait_d = wait_q + 1'b1;
      end
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_LOGO;
               busy_d    = 1'b1;
               logo_ok_d = 1'b1;
               csum_ok_d = 1'b0;
               csum_d    = 8'h00;
               tmo_d     = 1'b0;
               rd_req_d  = 1'b1;
               rd_addr_d = HDR_LOGO_START;
               idx_d     = '0;
               wait_d    = '0;
            end
         end
         ST_LOGO: begin
            if (beat) begin
               if (rd_data != logo_data) begin
                  logo_ok_d = 1'b0;
               end
               idx_d     = idx_q + 1'b1;
               rd_addr_d = rd_addr_q + 16'd1;
               if (rd_addr_q == HDR_LOGO_END) begin
                  state_d = ST_CSUM;
               end
            end
         end
         ST_CSUM: begin
            if (beat) begin
               csum_d    = csum_q - rd_data - 8'd1;
               rd_addr_d = rd_addr_q + 16'd1;
               if (rd_addr_q == HDR_CSUM_END) begin
                  state_d = ST_HCHK;
               end
            end
         end
         ST_HCHK: begin
            if (beat) begin
               csum_ok_d = (rd_data == csum_q);
               rd_req_d  = 1'b0;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               state_d   = ST_FINISH;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Abort on the last tolerated wait cycle of a stalled read
      if (stall && (wait_q == WW'(TIMEOUT - 1))) begin
         tmo_d     = 1'b1;
         logo_ok_d = 1'b0;
         csum_ok_d = 1'b0;
         rd_req_d  = 1'b0;
         busy_d    = 1'b0;
         done_d    = 1'b1;
         state_d   = ST_FINISH;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         logo_ok_q <= 1'b0;
         csum_ok_q <= 1'b0;
         csum_q    <= 8'h00;
         tmo_q     <= 1'b0;
         rd_req_q  <= 1'b0;
         rd_addr_q <= 16'h0000;
         idx_q     <= '0;
         wait_q    <= '0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         logo_ok_q <= logo_ok_d;
         csum_ok_q <= csum_ok_d;
         csum_q    <= csum_d;
         tmo_q     <= tmo_d;
         rd_req_q  <= rd_req_d;
         rd_addr_q <= rd_addr_d;
         idx_q     <= idx_d;
         wait_q    <= wait_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign logo_ok     = logo_ok_q;
   assign csum_ok     = csum_ok_q;
   assign csum        = csum_q;
   assign timeout_err = tmo_q;
   assign rd_req      = rd_req_q;
   assign rd_addr     = rd_addr_q;

endmodule

// File: tb/tb_cart_header_checker.sv
// Directed bench for cart_header_checker with a cartridge responder
// and boot-ROM model.
module tb_cart_header_checker;
   import gb_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        busy, done, logo_ok, csum_ok, timeout_err, rd_req;
   logic [7:0]  csum;
   logic [15:0] rd_addr;
   logic        rd_valid = 1'b0;
   logic [7:0]  rd_data = 8'h00;
   logic [7:0]  logo_addr, logo_data;

   cart_header_checker #(.LOGO_BASE(8'hA8), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .busy(busy), .done(done), .logo_ok(logo_ok),
      .csum_ok(csum_ok), .csum(csum), .timeout_err(timeout_err),
      .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .logo_addr(logo_addr), .logo_data(logo_data)
   );

   always #5 clk = ~clk;

   logic [7:0] rom [0:255];
   logic [7:0] hdr [0:511];
   assign logo_data = rom[logo_addr];

   int          passed = 0;
   int          total = 0;
   int          maxw = 0;
   logic [15:0] stall_addr = 16'hFFFF;
   int          wcnt = 0;
   int          wneed = 0;
   int          total_waits = 0;
   int          beats = 0;
   bit          bt_prev = 1'b0;
   bit          wt_prev = 1'b0;
   bit          stable_ok = 1'b1;
   logic [15:0] prev_addr = 16'h0000;
   logic [7:0]  exp_csum;
   int          cyc;

   // Responder: drives rd_valid/rd_data on the falling edge
   always @(negedge clk) begin
      if (bt_prev) begin
         beats++;
         wcnt = 0;
         wneed = (maxw == 0) ? 0 : int'($urandom_range(0, maxw));
      end
      if (wt_prev && rd_req && (rd_addr !== prev_addr)) stable_ok = 1'b0;
      rd_data = hdr[rd_addr[8:0]];
      if (!rd_req) begin
         rd_valid = 1'b1;
      end else if (rd_addr == stall_addr) begin
         rd_valid = 1'b0;
      end else if (wcnt < wneed) begin
         rd_valid = 1'b0;
         wcnt++;
         total_waits++;
      end else begin
         rd_valid = 1'b1;
      end
      bt_prev = rd_req && rd_valid;
      wt_prev = rd_req && !rd_valid;
      prev_addr = rd_addr;
   end

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic run_check(input int mw, input logic [15:0] sa,
                            input bit poke, output int c);
      maxw = mw;
      stall_addr = sa;
      beats = 0;
      total_waits = 0;
      wcnt = 0;
      wneed = (mw == 0) ? 0 : int'($urandom_range(0, mw));
      stable_ok = 1'b1;
      bt_prev = 1'b0;
      wt_prev = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      c = 1;
      chk("busy_c1", 16'(busy), 16'd1);
      chk("rd_req_c1", 16'(rd_req), 16'd1);
      chk("rd_addr_c1", rd_addr, 16'h0104);
      while (!done && c < 3000) begin
         start = (poke && c == 10);
         @(posedge clk);
         #1;
         c++;
      end
      chk("done_seen", 16'(done), 16'd1);
      chk("busy_at_done", 16'(busy), 16'd0);
      chk("rd_req_at_done", 16'(rd_req), 16'd0);
      start = poke;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("done_one_cycle", 16'(done), 16'd0);
      chk("busy_after", 16'(busy), 16'd0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;
      for (int i = 0; i < 512; i++) hdr[i] = 8'(i * 13) ^ 8'h3C;
      for (int i = 0; i < 48; i++) begin
         rom[8'hA8 + i] = 8'(i * 29 + 7);
         hdr[16'h0104 + i] = 8'(i * 29 + 7);
      end
      exp_csum = 8'h00;
      for (int a = 16'h0134; a <= 16'h014C; a++) exp_csum = exp_csum - hdr[a] - 8'd1;
      hdr[16'h014D] = exp_csum;

      #1 rst_n = 1'b0;
      #1;
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_done", 16'(done), 16'd0);
      chk("rst_logo_ok", 16'(logo_ok), 16'd0);
      chk("rst_csum_ok", 16'(csum_ok), 16'd0);
      chk("rst_tmo", 16'(timeout_err), 16'd0);
      chk("rst_rd_req", 16'(rd_req), 16'd0);
      chk("rst_csum", 16'(csum), 16'h0000);
      chk("rst_rd_addr", rd_addr, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Genuine header, zero waits, extra starts while busy and in FINISH
      run_check(0, 16'hFFFF, 1'b1, cyc);
      chk("good_cycles", 16'(cyc), 16'd75);
      chk("good_beats", 16'(beats), 16'd74);
      chk("good_logo_ok", 16'(logo_ok), 16'd1);
      chk("good_csum_ok", 16'(csum_ok), 16'd1);
      chk("good_csum", 16'(csum), 16'(exp_csum));
      chk("good_tmo", 16'(timeout_err), 16'd0);

      // Corrupted logo byte
      hdr[16'h0110] = hdr[16'h0110] ^ 8'h01;
      run_check(0, 16'hFFFF, 1'b0, cyc);
      chk("logo_bad_cycles", 16'(cyc), 16'd75);
      chk("logo_bad_beats", 16'(beats), 16'd74);
      chk("logo_bad_logo_ok", 16'(logo_ok), 16'd0);
      chk("logo_bad_csum_ok", 16'(csum_ok), 16'd1);
      hdr[16'h0110] = hdr[16'h0110] ^ 8'h01;

      // Checksum byte off by one
      hdr[16'h014D] = exp_csum + 8'd1;
      run_check(0, 16'hFFFF, 1'b0, cyc);
      chk("csum_bad_csum_ok", 16'(csum_ok), 16'd0);
      chk("csum_bad_logo_ok", 16'(logo_ok), 16'd1);
      chk("csum_bad_csum", 16'(csum), 16'(exp_csum));
      hdr[16'h014D] = exp_csum;

      // Random wait states
      run_check(5, 16'hFFFF, 1'b0, cyc);
      chk("wait_cycles", 16'(cyc), 16'(75 + total_waits));
      chk("wait_addr_stable", 16'(stable_ok), 16'd1);
      chk("wait_logo_ok", 16'(logo_ok), 16'd1);
      chk("wait_csum_ok", 16'(csum_ok), 16'd1);
      chk("wait_csum", 16'(csum), 16'(exp_csum));

      // Read timeout at 0x0140
      run_check(0, 16'h0140, 1'b0, cyc);
      chk("tmo_cycles", 16'(cyc), 16'd77);
      chk("tmo_beats", 16'(beats), 16'd60);
      chk("tmo_err", 16'(timeout_err), 16'd1);
      chk("tmo_logo_ok", 16'(logo_ok), 16'd0);
      chk("tmo_csum_ok", 16'(csum_ok), 16'd0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         chk("tmo_done_once", 16'(done), 16'd0);
      end

      // Reset during LOGO, then rerun
      maxw = 0;
      stall_addr = 16'hFFFF;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (20) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_busy", 16'(busy), 16'd0);
      chk("mid_rd_req", 16'(rd_req), 16'd0);
      chk("mid_rd_addr", rd_addr, 16'h0000);
      chk("mid_tmo", 16'(timeout_err), 16'd0);
      chk("mid_logo_ok", 16'(logo_ok), 16'd0);
      chk("mid_csum", 16'(csum), 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      run_check(0, 16'hFFFF, 1'b0, cyc);
      chk("rerun_cycles", 16'(cyc), 16'd75);
      chk("rerun_logo_ok", 16'(logo_ok), 16'd1);
      chk("rerun_csum_ok", 16'(csum_ok), 16'd1);
      chk("rerun_csum", 16'(csum), 16'(exp_csum));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/cart_header_checker.md
CART_HEADER_CHECKER -- requirements
Module: cart_header_checker

Interface
REQ-001 Parameter LOGO_BASE, 8'hA8: boot-ROM address of the first expected logo byte.
REQ-002 Parameter TIMEOUT, 16: maximum wait cycles per cartridge read before abort.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset is asynchronous and active-low.
REQ-005 start  in  1  request a header check; sampled only in IDLE.
REQ-006 busy  out  1  high from the cycle after start is accepted until done.
REQ-007 done  out  1  one-cycle pulse when a check completes or aborts.
REQ-008 logo_ok  out  1  all 48 cartridge logo bytes matched the boot-ROM copy.
REQ-009 csum_ok  out  1  computed header checksum equals cartridge byte 0x014D.
REQ-010 csum  out  8  computed header checksum.
REQ-011 timeout_err  out  1  last check aborted on read timeout.
REQ-012 rd_req  out  1  cartridge read request, registered.
REQ-013 rd_addr  out  16  cartridge read address, registered.
REQ-014 rd_valid  in  1  responder completes the read in this cycle.
REQ-015 rd_data  in  8  cartridge data, valid when rd_valid is high.
REQ-016 logo_addr  out  8  boot-ROM address, combinational LOGO_BASE + logo index.
REQ-017 logo_data  in  8  boot-ROM byte, combinational response to logo_addr.

Function
REQ-018 FSM states: IDLE, LOGO, CSUM, HCHK, FINISH.
REQ-019 IDLE + start: clear logo_ok/csum_ok/timeout_err/csum, set logo_ok=1, index=0, enter LOGO; rd_req=1, rd_addr=0x0104 the next cycle.
REQ-020 A beat completes in a cycle where rd_req and rd_valid are both 1; rd_data and logo_data are sampled in that cycle.
REQ-021 rd_addr stays stable while rd_req=1 and rd_valid=0; there is only one outstanding read.
REQ-022 After a beat completes with reads remaining, rd_req stays 1 and rd_addr advances by 1 the next cycle (back-to-back).
REQ-023 LOGO reads 0x0104-0x0133 (48 beats); any byte != logo_data clears logo_ok; all 48 beats are read on mismatch.
REQ-024 CSUM reads 0x0134-0x014C (25 beats), csum starting at 0: csum = csum - rd_data - 1, mod 256.
REQ-025 HCHK reads 0x014D: csum_ok = (rd_data == csum); rd_req drops the next cycle; enter FINISH.
REQ-026 FINISH: done=1 for one cycle, busy=0, return to IDLE; results hold until the next accepted start.
REQ-027 Zero-wait latency: start sampled at cycle 0, rd_req high cycles 1-74, done at cycle 75.
REQ-028 The wait counter resets on each new beat; if TIMEOUT consecutive cycles pass with rd_req=1 and rd_valid=0, the block sets timeout_err=1, logo_ok=0, csum_ok=0, drops rd_req, and enters FINISH.
REQ-029 start while busy is ignored; start in the FINISH cycle is ignored.
REQ-030 rd_valid while rd_req=0 is ignored.

Reset
REQ-031 Asserting rst_n low at any time, including mid-check, forces IDLE.
REQ-032 Reset values: busy, done, logo_ok, csum_ok, timeout_err, rd_req = 0; csum = 8'h00; rd_addr = 16'h0000.
REQ-033 Deassertion is synchronized by the integrator; the block requires no start for one cycle after release.

Structure
REQ-034 The shared package gb_pkg holds the FSM state enum and the constants HDR_LOGO_START=16'h0104, HDR_LOGO_END=16'h0133, HDR_CSUM_START=16'h0134, HDR_CSUM_END=16'h014C, HDR_CSUM_ADDR=16'h014D.
REQ-035 The block is a single module with no sub-module; the checksum accumulator and wait counter are inline.

Verification
REQ-036 Genuine header, rd_valid tied high: done at cycle 75, logo_ok=1, csum_ok=1, csum matches the value computed by the model.
REQ-037 Byte 0x0110 corrupted: all 74 beats are still issued; logo_ok=0, csum_ok=1.
REQ-038 Byte 0x014D off by one: csum_ok=0, logo_ok=1, csum unchanged from the good case.
REQ-039 Random 0-5 wait states per beat: rd_addr is stable during waits, results match REQ-036, and done arrives at cycle 75 plus the total number of waits.
REQ-040 rd_valid withheld at beat 0x0140: after 16 cycles, timeout_err=1, logo_ok=0, csum_ok=0, rd_req=0, done pulses once.
REQ-041 rst_n pulsed low during LOGO, then start issued again: all outputs are at reset values, and the new check completes identically to REQ-036.
